// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates trap/mispredict/jump redirects,
// holds one pending redirect for the fetch unit, and runs the core FSM.
module fetch_redirect_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            imem_ready_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mispredict_req_i,
    input  logic [XLEN-1:0] mispredict_pc_i,
    input  logic            jump_req_i,
    input  logic [XLEN-1:0] jump_pc_i,
    input  logic            halt_req_i,
    input  logic            resume_req_i,
    output logic            fetch_en_o,
    output logic            fetch_stall_o,
    output logic            fetch_branch_o,
    output logic [XLEN-1:0] fetch_branch_pc_o,
    output logic            flush_o,
    output logic [1:0]      epoch_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t            state;
    logic              pend_valid;
    logic [XLEN-1:0]   pend_pc;
    logic [1:0]        pend_prio;

    logic              in_valid;
    logic [1:0]        in_prio;
    logic [XLEN-1:0]   in_pc;
    logic              consume;
    logic              load;

    assign state_o           = state;
    assign fetch_en_o        = (state == RUN);
    assign fetch_stall_o     = ~imem_ready_i;
    assign fetch_branch_o    = pend_valid;
    assign fetch_branch_pc_o = pend_pc;

    // Pick the highest-priority incoming redirect (trap > mispredict > jump).
    always_comb begin
        in_valid = 1'b0;
        in_prio  = 2'd0;
        in_pc    = '0;
        if (trap_req_i) begin
            in_valid = 1'b1;
            in_prio  = 2'd2;
            in_pc    = trap_pc_i;
        end else if (mispredict_req_i) begin
            in_valid = 1'b1;
            in_prio  = 2'd1;
            in_pc    = mispredict_pc_i;
        end else if (jump_req_i) begin
            in_valid = 1'b1;
            in_prio  = 2'd0;
            in_pc    = jump_pc_i;
        end
    end

    // A pending entry leaves only when fetch is running and unstalled;
    // a new redirect wins if the slot frees up or it is not lower priority.
    assign consume = pend_valid & fetch_en_o & ~fetch_stall_o;
    assign load    = in_valid
                   & (~pend_valid | consume | (in_prio >= pend_prio));

    // Core run/halt FSM; dropping en_i always returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else if (!en_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= RUN;
                RUN:     if (halt_req_i) state <= HALT;
                HALT:    if (resume_req_i && !halt_req_i) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // Pending redirect slot plus the flush pulse and epoch it generates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            pend_prio  <= 2'd0;
            flush_o    <= 1'b0;
            epoch_o    <= 2'd0;
        end else begin
            if (load) begin
                pend_valid <= 1'b1;
                pend_pc    <= in_pc;
                pend_prio  <= in_prio;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
            flush_o <= load;
            epoch_o <= epoch_o + {1'b0, load};
        end
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en_i  input  1  global core enable.
REQ-005 SHALL have port imem_ready_i  input  1  instruction memory can accept a fetch this cycle.
REQ-006 SHALL have ports trap_req_i  input  1, and trap_pc_i  input  XLEN: trap/exception redirect (priority 2, highest).
REQ-007 SHALL have ports mispredict_req_i  input  1, and mispredict_pc_i  input  XLEN: execute-stage branch redirect (priority 1).
REQ-008 SHALL have ports jump_req_i  input  1, and jump_pc_i  input  XLEN: decode-stage jump redirect (priority 0).
REQ-009 SHALL have ports halt_req_i  input  1, and resume_req_i  input  1: debug halt/resume.
REQ-010 SHALL have port fetch_en_o  output  1  enable to fetch unit.
REQ-011 SHALL have port fetch_stall_o  output  1  stall to fetch unit.
REQ-012 SHALL have ports fetch_branch_o  output  1, and fetch_branch_pc_o  output  XLEN: redirect to fetch unit.
REQ-013 SHALL have ports flush_o  output  1, and epoch_o  output  2: younger-instruction kill pulse and fetch epoch.
REQ-014 SHALL have port state_o  output  2  FSM state: IDLE=00, RUN=01, HALT=10.

Function
REQ-015 SHALL implement FSM: IDLE->RUN when en_i=1; RUN->HALT when halt_req_i=1; HALT->RUN when resume_req_i=1 and halt_req_i=0; any state->IDLE when en_i=0; no other transitions; encoding 11 unreachable, decodes to IDLE.
REQ-016 SHALL drive fetch_en_o=1 only in RUN (combinational from state register).
REQ-017 SHALL drive fetch_stall_o = ~imem_ready_i, in all states.
REQ-018 SHALL select, in any state, the highest-priority asserted request in a cycle (trap > mispredict > jump) as the incoming redirect.
REQ-019 SHALL hold one pending redirect register: pend_valid, pend_pc, pend_prio (2 bits).
REQ-020 SHALL load an incoming redirect into the pending register when pend_valid=0, when the pending entry is consumed in the same cycle, or when incoming priority >= pend_prio; otherwise it SHALL drop the incoming redirect.
REQ-021 SHALL drive fetch_branch_o=pend_valid and fetch_branch_pc_o=pend_pc directly from registers; latency is exactly 1 cycle from request to fetch_branch_o.
REQ-022 SHALL consume the pending entry (clear pend_valid next cycle) in a cycle where pend_valid & fetch_en_o & ~fetch_stall_o; it SHALL hold fetch_branch_o/fetch_branch_pc_o stable otherwise.
REQ-023 SHALL, on consume plus simultaneous new request, present the new redirect next cycle (pend_valid stays 1, pc updated).
REQ-024 SHALL assert flush_o for exactly one cycle, registered, in the cycle after any redirect is loaded; it SHALL NOT assert for dropped requests.
REQ-025 SHALL increment epoch_o by 1 (mod 4, 3->0 wrap) in the same cycle flush_o asserts.
REQ-026 SHALL retain pending redirect across HALT and IDLE, applied on first unstalled RUN cycle.
REQ-027 SHALL allow halt_req_i and a redirect in the same cycle: both take effect.
REQ-028 SHALL treat request PCs as opaque XLEN values, with no alignment check or arithmetic.

Reset
REQ-029 SHALL, when rst_i=1 at a clock edge, set state=IDLE, pend_valid=0, pend_pc=0, pend_prio=0, flush_o=0, epoch_o=0, overriding all other inputs that cycle.
REQ-030 SHALL, on reset mid-operation, discard any pending redirect and deassert fetch_branch_o the following cycle.
REQ-031 SHALL give all outputs defined values during and after reset: fetch_en_o=0, fetch_branch_o=0, fetch_branch_pc_o=0, state_o=00.

Verification
REQ-032 SHALL cover boot: reset, en_i=1, imem_ready_i=1 -> state_o 00->01 next cycle, fetch_en_o=1, fetch_stall_o=0.
REQ-033 SHALL cover stall hold: RUN, imem_ready_i=0, mispredict_req_i=1 pc=0x100 -> fetch_branch_o=1, pc 0x100 held 3 stalled cycles, cleared 1 cycle after imem_ready_i=1; flush_o one pulse, epoch 0->1.
REQ-034 SHALL cover priority: same cycle jump 0x200, mispredict 0x300, trap 0x400 -> fetch_branch_pc_o=0x400; then jump 0x500 while pending stalled -> dropped, no flush; then trap 0x600 -> replaces, pc=0x600.
REQ-035 SHALL cover halt: pending 0x80 stalled, halt_req_i=1 -> HALT, fetch_en_o=0, fetch_branch_o stays 1; resume_req_i=1 with imem_ready_i=1 -> RUN, redirect consumed next cycle.
REQ-036 SHALL cover epoch wrap: 5 accepted redirects from epoch 0 -> epoch_o sequence 1,2,3,0,1.
REQ-037 SHALL cover reset mid-op: pending valid, rst_i=1 for one cycle -> fetch_branch_o=0, epoch_o=0, state_o=00 next cycle.
